// File: rtl/sprite_bounce_engine.sv
// rtl/sprite_bounce_engine.sv - priority-composited bouncing sprite renderer with per-frame motion FSM
//
// Purpose:
//   Composites up to NUM_SPRITES scaled sprites over the VGA pixel stream.
//   Index 0 has the highest priority. Texels are fetched from an external
//   synchronous ROM. Once per frame a sequential FSM moves each sprite, one
//   sprite per clock, and bounces it off the screen walls.
// Ports:
//   clk, rst               pixel clock, synchronous active-high reset
//   pix_x, pix_y           current pixel coordinates
//   available              1 = visible region
//   frame_start            1-clk pulse at start of vertical blank
//   sprite_en              per-sprite enable (0 = hidden and frozen)
//   rom_addr, rom_data     texel fetch; data {R,G,B,A} valid 1 clk after address
//   red, green, blue       registered colour, 2 clk after pixel inputs
//   busy                   motion FSM is updating sprites
//   frame_cnt              number of accepted frame_start pulses
// Optional feature:
//   BORDER_DEBUG_EN        paints a white/red/green screen border on visible
//                          pixels not covered by an opaque sprite texel.
module sprite_bounce_engine #(
    parameter int  NUM_SPRITES = 4,
    parameter int  SPR_W       = 50,
    parameter int  SPR_H       = 67,
    parameter int  SCALE_SH    = 1,
    parameter int  SCREEN_W    = 640,
    parameter int  SCREEN_H    = 480,
    parameter int  ANIM_SH     = 4,
    localparam int ROM_AW      = $clog2(NUM_SPRITES * 2 * SPR_H * SPR_W)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [15:0]            pix_x,
    input  logic [15:0]            pix_y,
    input  logic                   available,
    input  logic                   frame_start,
    input  logic [NUM_SPRITES-1:0] sprite_en,
    output logic [ROM_AW-1:0]      rom_addr,
    input  logic [15:0]            rom_data,
    output logic [3:0]             red,
    output logic [3:0]             green,
    output logic [3:0]             blue,
    output logic                   busy,
    output logic [31:0]            frame_cnt
);

    localparam int SPAN_W = SPR_W << SCALE_SH;
    localparam int SPAN_H = SPR_H << SCALE_SH;
    localparam int IW     = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
    localparam logic signed [16:0] X_LIM = 17'(SCREEN_W - SPAN_W);
    localparam logic signed [16:0] Y_LIM = 17'(SCREEN_H - SPAN_H);

    typedef enum logic {IDLE, UPD} state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [31:0]       frame_cnt_q, frame_cnt_d;
    logic              upd_en;

    logic [15:0]       x_q  [NUM_SPRITES];
    logic [15:0]       y_q  [NUM_SPRITES];
    logic signed [7:0] vx_q [NUM_SPRITES];
    logic signed [7:0] vy_q [NUM_SPRITES];

    logic [15:0]       x_nxt, y_nxt;
    logic signed [7:0] vx_nxt, vy_nxt;

    logic [NUM_SPRITES-1:0] hit;
    logic [IW-1:0]          sel;
    logic [15:0]            dx, dy;
    logic [ROM_AW-1:0]      rom_addr_d, rom_addr_q;
    logic                   hit_q, avail_q;
    logic [7:0]             pr, pg, pb;
    logic [3:0]             red_d, green_d, blue_d;
    logic [3:0]             red_q, green_q, blue_q;
`ifdef BORDER_DEBUG_EN
    logic [15:0]            px_q, py_q;
`endif

    // One axis of motion: returns {new position, new velocity}. The sum is
    // taken in 17b signed so an underflow past 0 is visible as negative.
    function automatic logic [23:0] bounce(input logic [15:0]        p,
                                           input logic signed [7:0]  v,
                                           input logic signed [16:0] lim);
        logic signed [16:0] n;
        logic signed [7:0]  nv;
        n  = $signed({1'b0, p}) + $signed({{9{v[7]}}, v});
        nv = -v;
        if (n < 0)
            return {16'd0, nv};
        else if (n > lim)
            return {lim[15:0], nv};
        else
            return {n[15:0], v};
    endfunction

    // Motion FSM: one sprite per clock while in UPD; disabled sprites still
    // take their slot so the sweep always lasts NUM_SPRITES clocks.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        frame_cnt_d = frame_cnt_q;
        upd_en      = 1'b0;
        case (state_q)
            IDLE: begin
                if (frame_start) begin
                    state_d     = UPD;
                    idx_d       = '0;
                    frame_cnt_d = frame_cnt_q + 32'd1;
                end
            end
            UPD: begin
                upd_en = sprite_en[idx_q];
                if (idx_q == IW'(NUM_SPRITES - 1))
                    state_d = IDLE;
                else
                    idx_d = idx_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
        {x_nxt, vx_nxt} = bounce(x_q[idx_q], vx_q[idx_q], X_LIM);
        {y_nxt, vy_nxt} = bounce(y_q[idx_q], vy_q[idx_q], Y_LIM);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            frame_cnt_q <= '0;
            for (int i = 0; i < NUM_SPRITES; i++) begin
                x_q[i]  <= 16'((i * SPAN_W) / 2);
                y_q[i]  <= '0;
                vx_q[i] <= 8'sd2;
                vy_q[i] <= 8'(i + 1);
            end
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            frame_cnt_q <= frame_cnt_d;
            if (upd_en) begin
                x_q[idx_q]  <= x_nxt;
                vx_q[idx_q] <= vx_nxt;
                y_q[idx_q]  <= y_nxt;
                vy_q[idx_q] <= vy_nxt;
            end
        end
    end

    // Stage 0: hit test in 17b so x+span cannot wrap, then lowest index wins.
    always_comb begin
        hit = '0;
        sel = '0;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            hit[i] = sprite_en[i]
                   && ({1'b0, pix_x} >= {1'b0, x_q[i]})
                   && ({1'b0, pix_x} <  ({1'b0, x_q[i]} + 17'(SPAN_W)))
                   && ({1'b0, pix_y} >= {1'b0, y_q[i]})
                   && ({1'b0, pix_y} <  ({1'b0, y_q[i]} + 17'(SPAN_H)));
        end
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (hit[i])
                sel = IW'(i);
        end
        dx = pix_x - x_q[sel];
        dy = pix_y - y_q[sel];
        rom_addr_d = '0;
        if (|hit)
            rom_addr_d = ROM_AW'(((int'(sel) * 2 + int'(frame_cnt_q[ANIM_SH])) * SPR_H
                                  + int'(dy >> SCALE_SH)) * SPR_W + int'(dx >> SCALE_SH));
    end

    // Stage 1: an all-zero texel is transparent and shows background even
    // if a lower-priority sprite also covers this pixel.
    always_comb begin
        pr      = {4'b0, rom_data[15:12]} * {4'b0, rom_data[3:0]};
        pg      = {4'b0, rom_data[11:8]}  * {4'b0, rom_data[3:0]};
        pb      = {4'b0, rom_data[7:4]}   * {4'b0, rom_data[3:0]};
        red_d   = 4'h0;
        green_d = 4'h0;
        blue_d  = 4'h0;
        if (avail_q) begin
            if (hit_q && (rom_data != 16'h0000)) begin
                red_d   = 4'(pr >> 4);
                green_d = 4'(pg >> 4);
                blue_d  = 4'(pb >> 4);
            end
`ifdef BORDER_DEBUG_EN
            else if ((px_q == 16'd0 && py_q == 16'd0) ||
                     (px_q == 16'(SCREEN_W - 1) && py_q == 16'(SCREEN_H - 1))) begin
                red_d   = 4'hF;
                green_d = 4'hF;
                blue_d  = 4'hF;
            end else if (px_q == 16'd0 || px_q == 16'(SCREEN_W - 1)) begin
                red_d   = 4'hF;
            end else if (py_q == 16'd0 || py_q == 16'(SCREEN_H - 1)) begin
                green_d = 4'hF;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rom_addr_q <= '0;
            hit_q      <= 1'b0;
            avail_q    <= 1'b0;
            red_q      <= 4'h0;
            green_q    <= 4'h0;
            blue_q     <= 4'h0;
`ifdef BORDER_DEBUG_EN
            px_q       <= '0;
            py_q       <= '0;
`endif
        end else begin
            rom_addr_q <= rom_addr_d;
            hit_q      <= |hit;
            avail_q    <= available;
            red_q      <= red_d;
            green_q    <= green_d;
            blue_q     <= blue_d;
`ifdef BORDER_DEBUG_EN
            px_q       <= pix_x;
            py_q       <= pix_y;
`endif
        end
    end

    assign rom_addr  = rom_addr_q;
    assign red       = red_q;
    assign green     = green_q;
    assign blue      = blue_q;
    assign busy      = (state_q == UPD);
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_sprite_bounce_engine.sv
// tb/tb_sprite_bounce_engine.sv - directed bench for sprite_bounce_engine with a frame-level reference model
module tb_sprite_bounce_engine;

    localparam int N      = 4;
    localparam int ROM_AW = $clog2(N * 2 * 67 * 50);
    localparam int SPW    = 100;
    localparam int SPH    = 134;
    localparam int XLIM   = 640 - SPW;
    localparam int YLIM   = 480 - SPH;

    logic              clk = 1'b0;
    logic              rst;
    logic [15:0]       pix_x, pix_y;
    logic              available;
    logic              frame_start;
    logic [N-1:0]      sprite_en;
    logic [ROM_AW-1:0] rom_addr;
    logic [15:0]       rom_data;
    logic [3:0]        red, green, blue;
    logic              busy;
    logic [31:0]       frame_cnt;

    logic              rom_mode;
    logic [15:0]       rom_fixed;

    int n_pass, n_total;

    int mx [N];
    int my [N];
    int mvx [N];
    int mvy [N];
    int fcnt, bcnt;
    bit e1_v, e1_av, e1_hit;
    int e1_addr, e1_px, e1_py;
    bit e2_v;
    int e2_rgb;

    sprite_bounce_engine dut (
        .clk         (clk),
        .rst         (rst),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .available   (available),
        .frame_start (frame_start),
        .sprite_en   (sprite_en),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .red         (red),
        .green       (green),
        .blue        (blue),
        .busy        (busy),
        .frame_cnt   (frame_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] rom_fn(input logic [ROM_AW-1:0] a);
        logic [31:0] t;
        t = 32'(a) * 32'd40503;
        if ((32'(a) % 5) == 3)
            return 16'h0000;
        return t[23:8];
    endfunction

    assign rom_data = rom_mode ? rom_fn(rom_addr) : rom_fixed;

    function automatic int shade(input int d);
        int r, g, b, a;
        r = (d >> 12) & 15;
        g = (d >> 8) & 15;
        b = (d >> 4) & 15;
        a = d & 15;
        return (((r * a) / 16) << 8) | (((g * a) / 16) << 4) | ((b * a) / 16);
    endfunction

    function automatic int bg(input int px, input int py);
        int c;
        c = 0;
`ifdef BORDER_DEBUG_EN
        if ((px == 0 && py == 0) || (px == 639 && py == 479)) c = 'hFFF;
        else if (px == 0 || px == 639)                       c = 'hF00;
        else if (py == 0 || py == 479)                       c = 'h0F0;
`else
        if (px < 0 || py < 0) c = 0;
`endif
        return c;
    endfunction

    task automatic bounce(inout int p, inout int v, input int lim);
        int n;
        n = p + v;
        if (n < 0) begin
            p = 0;
            v = -v;
        end else if (n > lim) begin
            p = lim;
            v = -v;
        end else begin
            p = n;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    endtask

    // Model: the whole frame's motion is applied at the accepting edge;
    // pixel samples taken while the DUT is mid-sweep are not compared.
    task automatic model_edge();
        int s, a, px, py;
        logic [15:0] rd;
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                mx[i]  = i * SPW / 2;
                my[i]  = 0;
                mvx[i] = 2;
                mvy[i] = i + 1;
            end
            fcnt = 0; bcnt = 0;
            e2_v = 1; e2_rgb = 0;
            e1_v = 1; e1_addr = 0; e1_av = 0; e1_hit = 0; e1_px = 0; e1_py = 0;
        end else begin
            e2_v = e1_v;
            if (!e1_av) begin
                e2_rgb = 0;
            end else begin
                rd = rom_mode ? rom_fn(ROM_AW'(e1_addr)) : rom_fixed;
                e2_rgb = (e1_hit && rd != 16'h0) ? shade(int'(rd)) : bg(e1_px, e1_py);
            end
            px = int'(pix_x);
            py = int'(pix_y);
            s = -1;
            for (int i = 0; i < N; i++)
                if (s < 0 && sprite_en[i] && px >= mx[i] && px < mx[i] + SPW && py >= my[i] && py < my[i] + SPH)
                    s = i;
            a = (fcnt / 16) % 2;
            e1_v = (bcnt == 0); e1_av = available; e1_hit = (s >= 0); e1_px = px; e1_py = py;
            e1_addr = 0;
            if (s >= 0)
                e1_addr = ((s * 2 + a) * 67 + (py - my[s]) / 2) * 50 + (px - mx[s]) / 2;
            if (bcnt > 0) begin
                bcnt--;
            end else if (frame_start) begin
                fcnt++;
                bcnt = N;
                for (int i = 0; i < N; i++)
                    if (sprite_en[i]) begin
                        bounce(mx[i], mvx[i], XLIM);
                        bounce(my[i], mvy[i], YLIM);
                    end
            end
        end
    endtask

    task automatic compare();
        if (e1_v) chk("rom_addr", int'(rom_addr), e1_addr);
        if (e2_v) chk("rgb", int'({red, green, blue}), e2_rgb);
        chk("busy", int'(busy), (bcnt > 0) ? 1 : 0);
        chk("frame_cnt", int'(frame_cnt), fcnt);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
    endtask

    task automatic do_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        repeat (5) tick();
    endtask

    int pts_x [14] = '{0, 99, 100, 99, 149, 150, 249, 250, 639, 0, 639, 320, 200, 175};
    int pts_y [14] = '{0, 133, 133, 134, 0, 0, 133, 50, 0, 479, 479, 240, 100, 60};

    initial begin
        int nb;
        n_pass = 0; n_total = 0;
        e1_v = 0; e2_v = 0; fcnt = 0; bcnt = 0;
        rst = 1'b1; pix_x = '0; pix_y = '0; available = 1'b0; frame_start = 1'b0;
        sprite_en = '1; rom_mode = 1'b0; rom_fixed = 16'h0000;

        tick();
        rst = 1'b0;
        chk("reset_rgb", int'({red, green, blue}), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_frame_cnt", int'(frame_cnt), 0);
        chk("reset_rom_addr", int'(rom_addr), 0);
        chk("model_s1_x", mx[1], 50);
        chk("model_s1_y", my[1], 0);
        chk("model_s1_vx", mvx[1], 2);
        chk("model_s1_vy", mvy[1], 2);

        // Pixel (0,0) on sprite 0; (15*15)>>4 = 14 on the F channels.
        available = 1'b1; rom_fixed = 16'hF0FF;
        tick();
        chk("px00_addr", int'(rom_addr), 0);
        tick();
        chk("px00_rgb_F0FF", int'({red, green, blue}), 'hE0E);
        rom_fixed = 16'h8888;
        tick(); tick();
        chk("px00_rgb_8888", int'({red, green, blue}), 'h444);

        // Overlap of sprites 0 and 1; then sprite 0 hidden.
        pix_x = 16'd60;
        tick();
        chk("px60_prio_addr", int'(rom_addr), 30);
        sprite_en = 4'b1110;
        tick();
        chk("px60_s1_addr", int'(rom_addr), 6705);
        sprite_en = 4'b1111;

        // Transparent texel over an overlapping lower-priority sprite.
        pix_x = 16'd60; pix_y = 16'd10; rom_fixed = 16'h0000;
        tick();
        chk("px60_10_addr", int'(rom_addr), 280);
        tick();
        chk("transparent_rgb", int'({red, green, blue}), 0);

        rom_fixed = 16'hFFFF; available = 1'b0;
        tick(); tick();
        chk("unavail_rgb", int'({red, green, blue}), 0);
        available = 1'b1;
        tick(); tick();
        chk("opaque_FFFF_rgb", int'({red, green, blue}), 'hEEE);

        // Pixel sweep with ROM-derived texels and varying enables.
        rom_mode = 1'b1;
        for (int k = 0; k < 14; k++) begin
            pix_x = 16'(pts_x[k]); pix_y = 16'(pts_y[k]);
            available = (k % 4) != 3;
            sprite_en = 4'((k * 5 + 15) % 16);
            tick();
        end
        sprite_en = 4'b1111; available = 1'b1;
        tick(); tick();

        // frame_start again on the 2nd UPD clock must be ignored.
        nb = 0;
        frame_start = 1'b1; tick(); nb += int'(busy);
        frame_start = 1'b0; tick(); nb += int'(busy);
        frame_start = 1'b1; tick(); nb += int'(busy);
        frame_start = 1'b0;
        repeat (4) begin tick(); nb += int'(busy); end
        chk("busy_cycles", nb, N);
        chk("frame_cnt_once", int'(frame_cnt), 1);

        // Walk sprite 0 to x=538 (269 frames at +2).
        for (int f = 0; f < 400 && mx[0] != 538; f++) begin
            pix_x = 16'((f * 37) % 640); pix_y = 16'((f * 53) % 480);
            available = (f % 3) != 0;
            do_frame();
        end
        chk("model_x0_538", mx[0], 538);
        chk("frame_cnt_269", int'(frame_cnt), 269);
        // Sprite 0 at (538,269), anim bit 0: texel row 1 col 1.
        pix_x = 16'd540; pix_y = 16'd271; available = 1'b1;
        tick();
        chk("probe_538_addr", int'(rom_addr), 51);

        do_frame();
        chk("model_x0_540", mx[0], 540);
        chk("model_vx0_p2", mvx[0], 2);
        do_frame();
        chk("model_x0_clamp", mx[0], 540);
        chk("model_vx0_m2", mvx[0], -2);
        do_frame();
        chk("model_x0_back", mx[0], 538);
        // 272 frames: anim bit set, sprite 0 at (538,272).
        pix_x = 16'd538; pix_y = 16'd272;
        tick();
        chk("probe_anim_addr", int'(rom_addr), 3350);

        // Reset in the middle of a motion sweep.
        frame_start = 1'b1; tick();
        frame_start = 1'b0; tick(); tick();
        rst = 1'b1; tick();
        rst = 1'b0;
        chk("midupd_frame_cnt", int'(frame_cnt), 0);
        chk("midupd_busy", int'(busy), 0);
        chk("model_reset_x1", mx[1], 50);
        pix_x = 16'd50; pix_y = 16'd0; sprite_en = 4'b1110;
        tick();
        chk("midupd_s1_addr", int'(rom_addr), 6700);
        tick(); tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
